// File: rtl/packet_rule_engine_if.sv
// Packet, verdict, rule-programming and software-clear signals of packet_rule_engine.
// The source/monitor side uses master; the engine uses slave.
interface packet_rule_engine_if #(
    parameter int ADDR_W    = 16,
    parameter int CMD_W     = 4,
    parameter int DATA_W    = 32,
    parameter int NUM_RULES = 8,
    parameter int CNT_W     = 16
);
    localparam int IDX_W = $clog2(NUM_RULES);

    logic              cfg_we;
    logic [IDX_W-1:0]  cfg_idx;
    logic              cfg_en;
    logic [ADDR_W-1:0] cfg_addr_val;
    logic [ADDR_W-1:0] cfg_addr_mask;
    logic [CMD_W-1:0]  cfg_cmd_val;
    logic [CMD_W-1:0]  cfg_cmd_mask;
    logic [DATA_W-1:0] cfg_data_val;
    logic [DATA_W-1:0] cfg_data_mask;

    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] addr_in;
    logic [CMD_W-1:0]  cmd_in;
    logic [DATA_W-1:0] data_in;

    logic              out_valid;
    logic              out_ready;
    logic              rule_violation;
    logic [IDX_W-1:0]  hit_idx;
    logic              lock_hit;
    logic [CNT_W-1:0]  viol_cnt;
    logic              locked;

    logic              cnt_clr;
    logic              lock_clr;

    modport master (
        output cfg_we, cfg_idx, cfg_en, cfg_addr_val, cfg_addr_mask,
               cfg_cmd_val, cfg_cmd_mask, cfg_data_val, cfg_data_mask,
               in_valid, addr_in, cmd_in, data_in, out_ready, cnt_clr, lock_clr,
        input  in_ready, out_valid, rule_violation, hit_idx, lock_hit, viol_cnt, locked
    );

    modport slave (
        input  cfg_we, cfg_idx, cfg_en, cfg_addr_val, cfg_addr_mask,
               cfg_cmd_val, cfg_cmd_mask, cfg_data_val, cfg_data_mask,
               in_valid, addr_in, cmd_in, data_in, out_ready, cnt_clr, lock_clr,
        output in_ready, out_valid, rule_violation, hit_idx, lock_hit, viol_cnt, locked
    );
endinterface

// File: rtl/packet_rule_engine.sv
// Run-time programmable masked-match rule table with a registered verdict,
// saturating violation counter and threshold-armed lockout.
module packet_rule_engine #(
    parameter int ADDR_W      = 16,
    parameter int CMD_W       = 4,
    parameter int DATA_W      = 32,
    parameter int NUM_RULES   = 8,
    parameter int CNT_W       = 16,
    parameter int LOCK_THRESH = 0,
    localparam int IDX_W      = $clog2(NUM_RULES)
) (
    input logic                 clk,
    input logic                 rst,
    packet_rule_engine_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] THRESH  = CNT_W'(LOCK_THRESH);

    logic [NUM_RULES-1:0] en_q, en_d;
    logic [ADDR_W-1:0]    addr_val_q  [NUM_RULES];
    logic [ADDR_W-1:0]    addr_val_d  [NUM_RULES];
    logic [ADDR_W-1:0]    addr_mask_q [NUM_RULES];
    logic [ADDR_W-1:0]    addr_mask_d [NUM_RULES];
    logic [CMD_W-1:0]     cmd_val_q   [NUM_RULES];
    logic [CMD_W-1:0]     cmd_val_d   [NUM_RULES];
    logic [CMD_W-1:0]     cmd_mask_q  [NUM_RULES];
    logic [CMD_W-1:0]     cmd_mask_d  [NUM_RULES];
    logic [DATA_W-1:0]    data_val_q  [NUM_RULES];
    logic [DATA_W-1:0]    data_val_d  [NUM_RULES];
    logic [DATA_W-1:0]    data_mask_q [NUM_RULES];
    logic [DATA_W-1:0]    data_mask_d [NUM_RULES];

    logic             out_valid_q, out_valid_d;
    logic             viol_q, viol_d;
    logic [IDX_W-1:0] hit_idx_q, hit_idx_d;
    logic             lock_hit_q, lock_hit_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             locked_q, locked_d;

    logic [NUM_RULES-1:0] match;
    logic                 any_match;
    logic [IDX_W-1:0]     first_idx;
    logic                 in_ready;
    logic                 accept;
    logic                 verdict_viol;
    logic                 arm;
    logic [CNT_W-1:0]     cnt_base;

    // Slots beyond NUM_RULES never compare equal, so out-of-range writes drop out.
    always_comb begin
        en_d        = en_q;
        addr_val_d  = addr_val_q;
        addr_mask_d = addr_mask_q;
        cmd_val_d   = cmd_val_q;
        cmd_mask_d  = cmd_mask_q;
        data_val_d  = data_val_q;
        data_mask_d = data_mask_q;
        for (int k = 0; k < NUM_RULES; k++) begin
            if (bus.cfg_we && bus.cfg_idx == IDX_W'(k)) begin
                en_d[k]        = bus.cfg_en;
                addr_val_d[k]  = bus.cfg_addr_val;
                addr_mask_d[k] = bus.cfg_addr_mask;
                cmd_val_d[k]   = bus.cfg_cmd_val;
                cmd_mask_d[k]  = bus.cfg_cmd_mask;
                data_val_d[k]  = bus.cfg_data_val;
                data_mask_d[k] = bus.cfg_data_mask;
            end
        end
    end

    always_comb begin
        match = '0;
        for (int k = 0; k < NUM_RULES; k++) begin
            match[k] = en_q[k]
                && ((bus.addr_in & addr_mask_q[k]) == (addr_val_q[k] & addr_mask_q[k]))
                && ((bus.cmd_in  & cmd_mask_q[k])  == (cmd_val_q[k]  & cmd_mask_q[k]))
                && ((bus.data_in & data_mask_q[k]) == (data_val_q[k] & data_mask_q[k]));
        end
    end

    // Scanning downward leaves the lowest matching index as the winner.
    always_comb begin
        first_idx = '0;
        for (int k = NUM_RULES - 1; k >= 0; k--) begin
            if (match[k]) begin
                first_idx = IDX_W'(k);
            end
        end
    end

    assign any_match = |match;
    assign in_ready  = !out_valid_q || bus.out_ready;
    assign accept    = bus.in_valid && in_ready;

    always_comb begin
        verdict_viol = locked_q || any_match;
        out_valid_d  = out_valid_q;
        viol_d       = viol_q;
        hit_idx_d    = hit_idx_q;
        lock_hit_d   = lock_hit_q;
        if (accept) begin
            out_valid_d = 1'b1;
            viol_d      = verdict_viol;
            hit_idx_d   = first_idx;
            lock_hit_d  = locked_q && !any_match;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // A clear and a violating accept in the same cycle leave the count at one.
    always_comb begin
        cnt_base = bus.cnt_clr ? '0 : cnt_q;
        cnt_d    = cnt_base;
        if (accept && verdict_viol && cnt_base != CNT_MAX) begin
            cnt_d = cnt_base + CNT_W'(1);
        end
        arm      = (LOCK_THRESH != 0) && accept && verdict_viol && (cnt_d == THRESH);
        locked_d = bus.lock_clr ? 1'b0 : (locked_q || arm);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q <= '0;
            for (int k = 0; k < NUM_RULES; k++) begin
                addr_val_q[k]  <= '0;
                addr_mask_q[k] <= '0;
                cmd_val_q[k]   <= '0;
                cmd_mask_q[k]  <= '0;
                data_val_q[k]  <= '0;
                data_mask_q[k] <= '0;
            end
            out_valid_q <= 1'b0;
            viol_q      <= 1'b0;
            hit_idx_q   <= '0;
            lock_hit_q  <= 1'b0;
            cnt_q       <= '0;
            locked_q    <= 1'b0;
        end else begin
            en_q        <= en_d;
            addr_val_q  <= addr_val_d;
            addr_mask_q <= addr_mask_d;
            cmd_val_q   <= cmd_val_d;
            cmd_mask_q  <= cmd_mask_d;
            data_val_q  <= data_val_d;
            data_mask_q <= data_mask_d;
            out_valid_q <= out_valid_d;
            viol_q      <= viol_d;
            hit_idx_q   <= hit_idx_d;
            lock_hit_q  <= lock_hit_d;
            cnt_q       <= cnt_d;
            locked_q    <= locked_d;
        end
    end

    assign bus.in_ready       = in_ready;
    assign bus.out_valid      = out_valid_q;
    assign bus.rule_violation = viol_q;
    assign bus.hit_idx        = hit_idx_q;
    assign bus.lock_hit       = lock_hit_q;
    assign bus.viol_cnt       = cnt_q;
    assign bus.locked         = locked_q;
endmodule

// File: tb/tb_packet_rule_engine.sv
// Directed bench for packet_rule_engine: dut_a (8 rules, 16-bit counter, lockout at 3)
// and dut_s (6 rules, 2-bit counter, no lockout) share one stimulus stream.
module tb_packet_rule_engine;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        cfg_we;
    logic [2:0]  cfg_idx;
    logic        cfg_en;
    logic [15:0] cfg_addr_val, cfg_addr_mask;
    logic [3:0]  cfg_cmd_val, cfg_cmd_mask;
    logic [31:0] cfg_data_val, cfg_data_mask;
    logic        in_valid;
    logic [15:0] addr_in;
    logic [3:0]  cmd_in;
    logic [31:0] data_in;
    logic        out_ready;
    logic        cnt_clr;
    logic        lock_clr;

    int checks = 0;
    int errors = 0;

    packet_rule_engine_if #(.NUM_RULES(8), .CNT_W(16)) if_a ();
    packet_rule_engine_if #(.NUM_RULES(6), .CNT_W(2))  if_s ();

    packet_rule_engine #(.NUM_RULES(8), .CNT_W(16), .LOCK_THRESH(3)) dut_a (
        .clk(clk), .rst(rst), .bus(if_a)
    );
    packet_rule_engine #(.NUM_RULES(6), .CNT_W(2), .LOCK_THRESH(0)) dut_s (
        .clk(clk), .rst(rst), .bus(if_s)
    );

    assign if_a.cfg_we        = cfg_we;
    assign if_a.cfg_idx       = cfg_idx;
    assign if_a.cfg_en        = cfg_en;
    assign if_a.cfg_addr_val  = cfg_addr_val;
    assign if_a.cfg_addr_mask = cfg_addr_mask;
    assign if_a.cfg_cmd_val   = cfg_cmd_val;
    assign if_a.cfg_cmd_mask  = cfg_cmd_mask;
    assign if_a.cfg_data_val  = cfg_data_val;
    assign if_a.cfg_data_mask = cfg_data_mask;
    assign if_a.in_valid      = in_valid;
    assign if_a.addr_in       = addr_in;
    assign if_a.cmd_in        = cmd_in;
    assign if_a.data_in       = data_in;
    assign if_a.out_ready     = out_ready;
    assign if_a.cnt_clr       = cnt_clr;
    assign if_a.lock_clr      = lock_clr;

    assign if_s.cfg_we        = cfg_we;
    assign if_s.cfg_idx       = cfg_idx;
    assign if_s.cfg_en        = cfg_en;
    assign if_s.cfg_addr_val  = cfg_addr_val;
    assign if_s.cfg_addr_mask = cfg_addr_mask;
    assign if_s.cfg_cmd_val   = cfg_cmd_val;
    assign if_s.cfg_cmd_mask  = cfg_cmd_mask;
    assign if_s.cfg_data_val  = cfg_data_val;
    assign if_s.cfg_data_mask = cfg_data_mask;
    assign if_s.in_valid      = in_valid;
    assign if_s.addr_in       = addr_in;
    assign if_s.cmd_in        = cmd_in;
    assign if_s.data_in       = data_in;
    assign if_s.out_ready     = out_ready;
    assign if_s.cnt_clr       = cnt_clr;
    assign if_s.lock_clr      = lock_clr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic set_rule(input logic [2:0] idx, input logic en,
                            input logic [15:0] av, input logic [15:0] am,
                            input logic [3:0] cv, input logic [3:0] cm,
                            input logic [31:0] dv, input logic [31:0] dm);
        cfg_idx = idx; cfg_en = en;
        cfg_addr_val = av; cfg_addr_mask = am;
        cfg_cmd_val = cv;  cfg_cmd_mask = cm;
        cfg_data_val = dv; cfg_data_mask = dm;
    endtask

    task automatic program_rule(input logic [2:0] idx, input logic en,
                                input logic [15:0] av, input logic [15:0] am,
                                input logic [3:0] cv, input logic [3:0] cm,
                                input logic [31:0] dv, input logic [31:0] dm);
        set_rule(idx, en, av, am, cv, cm, dv, dm);
        cfg_we = 1'b1;
        tick();
        cfg_we = 1'b0;
    endtask

    // One accepted packet; any strobes set beforehand ride along with it.
    task automatic send(input logic [15:0] a, input logic [3:0] c, input logic [31:0] d);
        addr_in = a; cmd_in = c; data_in = d;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        cfg_we = 1'b0; cnt_clr = 1'b0; lock_clr = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cfg_we = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        cnt_clr = 1'b0; lock_clr = 1'b0;
        set_rule(3'd0, 1'b0, 16'h0, 16'h0, 4'h0, 4'h0, 32'h0, 32'h0);
        addr_in = '0; cmd_in = '0; data_in = '0;
        tick();
        tick();
        rst = 1'b0;
        $display("[TB] reset values");
        check("rst_out_valid", if_a.out_valid, 0);
        check("rst_violation", if_a.rule_violation, 0);
        check("rst_hit_idx", if_a.hit_idx, 0);
        check("rst_lock_hit", if_a.lock_hit, 0);
        check("rst_viol_cnt", if_a.viol_cnt, 0);
        check("rst_locked", if_a.locked, 0);
        check("rst_in_ready", if_a.in_ready, 1);

        $display("[TB] empty table");
        send(16'h0000, 4'h0, 32'hDEADBEEF);
        check("empty_out_valid", if_s.out_valid, 1);
        check("empty_violation", if_s.rule_violation, 0);
        check("empty_hit_idx", if_s.hit_idx, 0);
        check("empty_viol_cnt", if_s.viol_cnt, 0);
        tick();
        check("idle_out_valid", if_s.out_valid, 0);

        $display("[TB] legacy rules and priority");
        program_rule(3'd0, 1'b1, 16'h0000, 16'hFFFF, 4'h0, 4'h0, 32'h0, 32'h0);
        program_rule(3'd1, 1'b1, 16'h0000, 16'h0000, 4'h0, 4'h0, 32'hDEADBEEF, 32'hFFFFFFFF);
        program_rule(3'd2, 1'b1, 16'h1234, 16'hFFFF, 4'h2, 4'hF, 32'h0, 32'h0);
        send(16'h1234, 4'h2, 32'h0);
        check("r2_violation", if_s.rule_violation, 1);
        check("r2_hit_idx", if_s.hit_idx, 2);
        check("r2_viol_cnt", if_s.viol_cnt, 1);
        send(16'h0000, 4'h0, 32'hDEADBEEF);
        check("r0_violation", if_s.rule_violation, 1);
        check("r0_hit_idx", if_s.hit_idx, 0);
        check("r0_viol_cnt", if_s.viol_cnt, 2);
        send(16'h1234, 4'h3, 32'h0);
        check("cmd_miss_violation", if_s.rule_violation, 0);
        check("cmd_miss_viol_cnt", if_s.viol_cnt, 2);

        $display("[TB] masking");
        program_rule(3'd3, 1'b1, 16'hA000, 16'hF000, 4'h0, 4'h0, 32'h0, 32'h0);
        send(16'hA5A5, 4'h0, 32'h0);
        check("mask_hit_violation", if_s.rule_violation, 1);
        check("mask_hit_idx", if_s.hit_idx, 3);
        send(16'hB000, 4'h0, 32'h0);
        check("mask_miss_violation", if_s.rule_violation, 0);
        program_rule(3'd3, 1'b0, 16'hA000, 16'hF000, 4'h0, 4'h0, 32'h0, 32'h0);
        send(16'hA5A5, 4'h0, 32'h0);
        check("disabled_violation", if_s.rule_violation, 0);
        // Slot 7 does not exist in the six-rule instance.
        program_rule(3'd7, 1'b1, 16'h0, 16'h0, 4'h0, 4'h0, 32'h0, 32'h0);
        send(16'h5555, 4'h0, 32'h0);
        check("oor_idx_violation", if_s.rule_violation, 0);

        $display("[TB] backpressure");
        do_reset();
        program_rule(3'd0, 1'b1, 16'h1111, 16'hFFFF, 4'h0, 4'h0, 32'h0, 32'h0);
        program_rule(3'd1, 1'b1, 16'h0, 16'h0, 4'h0, 4'h0, 32'h0, 32'h0);
        out_ready = 1'b0;
        addr_in = 16'h1111; cmd_in = '0; data_in = '0;
        in_valid = 1'b1;
        tick();
        check("bp_first_out_valid", if_a.out_valid, 1);
        check("bp_first_hit_idx", if_a.hit_idx, 0);
        check("bp_first_viol_cnt", if_a.viol_cnt, 1);
        check("bp_first_in_ready", if_a.in_ready, 0);
        addr_in = 16'h2222;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("bp_hold_in_ready", if_a.in_ready, 0);
            check("bp_hold_out_valid", if_a.out_valid, 1);
            check("bp_hold_hit_idx", if_a.hit_idx, 0);
            check("bp_hold_viol_cnt", if_a.viol_cnt, 1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        check("bp_drain_out_valid", if_a.out_valid, 0);
        check("bp_drain_viol_cnt", if_a.viol_cnt, 1);

        $display("[TB] lockout");
        do_reset();
        program_rule(3'd0, 1'b1, 16'hBAD0, 16'hFFFF, 4'h0, 4'h0, 32'h0, 32'h0);
        send(16'hBAD0, 4'h0, 32'h0);
        send(16'hBAD0, 4'h0, 32'h0);
        check("lk_two_locked", if_a.locked, 0);
        check("lk_two_viol_cnt", if_a.viol_cnt, 2);
        send(16'hBAD0, 4'h0, 32'h0);
        check("lk_three_locked", if_a.locked, 1);
        check("lk_three_lock_hit", if_a.lock_hit, 0);
        check("lk_three_viol_cnt", if_a.viol_cnt, 3);
        send(16'h0001, 4'h0, 32'h0);
        check("lk_clean_violation", if_a.rule_violation, 1);
        check("lk_clean_lock_hit", if_a.lock_hit, 1);
        check("lk_clean_hit_idx", if_a.hit_idx, 0);
        check("lk_clean_viol_cnt", if_a.viol_cnt, 4);
        lock_clr = 1'b1;
        send(16'hBAD0, 4'h0, 32'h0);
        check("lk_clr_locked", if_a.locked, 0);
        check("lk_clr_lock_hit", if_a.lock_hit, 0);
        check("lk_clr_viol_cnt", if_a.viol_cnt, 5);
        cnt_clr = 1'b1;
        send(16'hBAD0, 4'h0, 32'h0);
        check("lk_cntclr_viol_cnt", if_a.viol_cnt, 1);
        send(16'hBAD0, 4'h0, 32'h0);
        // Count reaches the threshold in the same cycle as lock_clr.
        lock_clr = 1'b1;
        send(16'hBAD0, 4'h0, 32'h0);
        check("lk_race_viol_cnt", if_a.viol_cnt, 3);
        check("lk_race_locked", if_a.locked, 0);
        send(16'h0001, 4'h0, 32'h0);
        check("lk_after_violation", if_a.rule_violation, 0);
        check("lk_after_lock_hit", if_a.lock_hit, 0);

        $display("[TB] saturation and races");
        do_reset();
        program_rule(3'd0, 1'b1, 16'hBAD0, 16'hFFFF, 4'h0, 4'h0, 32'h0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            send(16'hBAD0, 4'h0, 32'h0);
            check("sat_viol_cnt", if_s.viol_cnt, (i < 3) ? i + 1 : 3);
        end
        cnt_clr = 1'b1;
        send(16'hBAD0, 4'h0, 32'h0);
        check("sat_clr_race_viol_cnt", if_s.viol_cnt, 1);
        set_rule(3'd1, 1'b1, 16'h0042, 16'hFFFF, 4'h0, 4'h0, 32'h0, 32'h0);
        cfg_we = 1'b1;
        send(16'h0042, 4'h0, 32'h0);
        check("cfg_race_violation", if_s.rule_violation, 0);
        send(16'h0042, 4'h0, 32'h0);
        check("cfg_new_violation", if_s.rule_violation, 1);
        check("cfg_new_hit_idx", if_s.hit_idx, 1);
        check("cfg_new_viol_cnt", if_s.viol_cnt, 2);

        $display("[TB] reset mid-stream");
        tick();
        out_ready = 1'b0;
        send(16'hBAD0, 4'h0, 32'h0);
        check("mid_pending_out_valid", if_s.out_valid, 1);
        check("mid_pending_viol_cnt", if_s.viol_cnt, 3);
        do_reset();
        check("mid_rst_out_valid", if_s.out_valid, 0);
        check("mid_rst_violation", if_s.rule_violation, 0);
        check("mid_rst_viol_cnt", if_s.viol_cnt, 0);
        out_ready = 1'b1;
        send(16'hBAD0, 4'h0, 32'h0);
        check("mid_cleared_table", if_s.rule_violation, 0);
        check("mid_cleared_out_valid", if_s.out_valid, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
